instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//   Instruction-fetch stage: owns the PC, issues word fetches to instruction memory,
//   and holds the fetched instruction in an IF/ID output register.
//   Sits directly upstream of the main control decoder; opcode (instr[31:26]) drives its 6-bit ins input.
//   Supports downstream stall (1-entry skid buffer) and branch/jump redirect with in-flight squash.
// PARAMETERS
//   PC_WIDTH   32            width of PC, addresses, and pc+4 arithmetic
//   RESET_PC   32'h00000000  first fetch address after reset (bits [1:0] must be 0)
// PORTS
//   clk          in   1         single clock; all state updates on posedge clk
//   rst_n        in   1         synchronous, active-low reset
//   imem_req     out  1         fetch request, 1-cycle pulse; memory always accepts
//   imem_addr    out  PC_WIDTH  fetch address, word aligned; valid when imem_req=1
//   imem_rvalid  in   1         fetched word valid, >=1 cycle after imem_req, in order
//   imem_rdata   in   32        fetched instruction word
//   stall        in   1         downstream cannot accept; IF/ID register holds
//   redirect     in   1         taken branch/jump; squash fetch path
//   redirect_pc  in   PC_WIDTH  new fetch target; bits [1:0] forced to 0 internally
//   if_valid     out  1         IF/ID register holds a live instruction
//   if_instr     out  32        IF/ID instruction
//   if_pc        out  PC_WIDTH  address of if_instr
//   if_pc4       out  PC_WIDTH  if_pc + 4, combinational, modulo 2^PC_WIDTH
//   opcode       out  6         if_instr[31:26], combinational; feeds control decoder ins
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): pc=RESET_PC; state=S_REQ; if_valid=0; if_instr=0; if_pc=0; skid_valid=0.
//     imem_req is forced 0 while rst_n=0.
//   FSM states: S_REQ, S_WAIT, S_DROP. At most one fetch outstanding.
//   S_REQ:
//     If !skid_valid && !redirect: imem_req=1, imem_addr=pc; req_pc<=pc; pc<=pc+4; go S_WAIT.
//     Otherwise: no request; stay in S_REQ.
//   S_WAIT, on imem_rvalid:
//     If IF/ID is free (!if_valid || !stall): load IF/ID with {rdata, req_pc}; if_valid<=1.
//     Otherwise: load skid with {rdata, req_pc}; skid_valid<=1.
//     Then go S_REQ.
//   S_DROP: wait for imem_rvalid; discard the data; go S_REQ. Redirect in S_DROP only updates pc.
//   Output advance when !stall:
//     If skid_valid: IF/ID<=skid; skid_valid<=0.
//     Else if a new word arrives: IF/ID<=new word.
//     Else: if_valid<=0.
//     Skid is drained before any new word is accepted. Order is never violated.
//   Stall=1: IF/ID holds all its values. At most 1 extra word is buffered; no further requests issue.
//   Redirect has priority over everything except reset. In the same cycle:
//     pc<=redirect_pc & ~3; if_valid<=0; skid_valid<=0.
//     S_WAIT and !imem_rvalid -> go S_DROP.
//     S_WAIT and imem_rvalid  -> data discarded; go S_REQ.
//     S_REQ -> no request this cycle; the next cycle requests redirect_pc.
//   Redirect and stall together: redirect wins; IF/ID is invalidated.
//   PC arithmetic: unsigned, modulo 2^PC_WIDTH. 0xFFFFFFFC + 4 = 0x00000000.
//   Reset mid-operation clears all state. A stray imem_rvalid while in S_REQ is ignored.
//   Throughput: 1 instruction per (memory latency + 1) cycles. Latency 1 gives 1 instruction every 2 cycles.
// TESTING
//   T1 Reset, mem latency 1, no stall; mem[0]=0x8C010004
//      -> req addrs 0x0, 0x4, 0x8 on cycles 1, 3, 5
//      -> if_valid with if_pc=0x0, opcode=6'b100011, if_pc4=0x4.
//   T2 stall=1 from the cycle before rvalid of addr 0x4, for 4 cycles
//      -> word lands in skid; no imem_req; if_pc stays 0x0
//      -> after stall drops: if_pc=0x4 next cycle, then req 0x8.
//   T3 redirect=1 with redirect_pc=0x43 while in S_WAIT for 0x8, mem latency 3
//      -> returned 0x8 word never appears on if_valid
//      -> next imem_addr=0x40.
//   T4 redirect coincident with imem_rvalid, and with stall=1 and skid full
//      -> if_valid=0 and skid_valid=0 next cycle
//      -> next req at redirect target; no S_DROP wait.
//   T5 rst_n=0 for 1 cycle during S_WAIT with skid full
//      -> outputs at reset values; stray rvalid ignored; next req addr=RESET_PC.
//   T6 redirect_pc=0xFFFFFFFC -> fetches 0xFFFFFFFC, then 0x00000000; if_pc4 of the first = 0x0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem fetch in flight and presents
// fetched words through an IF/ID register backed by a one-entry skid buffer.
module instr_fetch #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [PC_WIDTH-1:0] if_pc4,
    output logic [5:0]          opcode
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                if_valid_q, if_valid_d;
    logic [31:0]         if_instr_q, if_instr_d;
    logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
    logic                skid_valid_q, skid_valid_d;
    logic [31:0]         skid_instr_q, skid_instr_d;
    logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic                req_raw;
    logic                new_word;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        req_raw      = 1'b0;
        new_word     = (state_q == S_WAIT) && imem_rvalid && !redirect;

        // A full skid blocks new requests, so skid content and an in-flight fetch never coexist.
        case (state_q)
            S_REQ: begin
                if (!skid_valid_q && !redirect) begin
                    req_raw  = 1'b1;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_WIDTH'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (!stall) begin
            if (skid_valid_q) begin
                if_valid_d   = 1'b1;
                if_instr_d   = skid_instr_q;
                if_pc_d      = skid_pc_q;
                skid_valid_d = 1'b0;
            end else if (new_word) begin
                if_valid_d = 1'b1;
                if_instr_d = imem_rdata;
                if_pc_d    = req_pc_q;
            end else begin
                if_valid_d = 1'b0;
            end
        end else if (new_word) begin
            if (!if_valid_q) begin
                if_valid_d = 1'b1;
                if_instr_d = imem_rdata;
                if_pc_d    = req_pc_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = req_pc_q;
            end
        end

        // An unanswered fetch must still be absorbed, hence S_DROP rather than a fresh request.
        if (redirect) begin
            pc_d         = redirect_pc & ~(PC_WIDTH'(3));
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            if (state_q == S_WAIT && !imem_rvalid) state_d = S_DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req  = req_raw & rst_n;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_pc4    = if_pc_q + PC_WIDTH'(4);
    assign opcode    = if_instr_q[31:26];

endmodule
